ap_com_bank: RTL and testbench
==============================

Name: ap_com_bank

Overview:
Runtime-programmable bank of NUM_COM approximate compressor cells for the approximate unsigned Wallace multiplier family.
- Each cell is an IN_W-input, 1-output LUT with a 2**IN_W-bit truth table held in registers, not fixed at elaboration, so the evolutionary search can reprogram compressors without resynthesis.
- Sits between partial-product generation and the final adder, inside a valid/ready pipeline of PIPE stages.
- 2- and 3-input compressors are 4-input cells whose truth tables ignore the unused inputs.

Parameters:
NUM_COM, 17, number of compressor cells.
IN_W, 4, inputs per cell; truth table width TT_W = 2**IN_W.
PIPE, 1, output pipeline depth, legal 1..3.
CFG_AW, $clog2(NUM_COM), config address width (derived; not overridden).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_we  in  1  truth-table write strobe.
cfg_addr  in  CFG_AW  cell index for the write.
cfg_data  in  TT_W  truth table; bit k is the output for input pattern k, with cell input 0 as the MSB of k.
cfg_err  out  1  sticky flag: a write to cfg_addr >= NUM_COM occurred.
in_valid  in  1  input beat valid.
in_ready  out  1  bank can accept a beat.
in_data  in  NUM_COM*IN_W  cell c uses bits [c*IN_W +: IN_W].
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  NUM_COM  bit c is the output of cell c.
beat_cnt  out  32  accepted-beat counter, saturating at 2**32-1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All truth tables 0.
  - out_valid 0, out_data 0, cfg_err 0, beat_cnt 0.
  - All pipeline valid bits 0.
  - in_ready 1 once reset is released.
- Lookup:
  - out bit c = table[c][in_data[c*IN_W +: IN_W]].
  - Evaluated combinationally on the accept edge and captured into stage 1.
  - Later stages carry the registered result only.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Each stage s holds a valid bit and data, and advances when stage s+1 is empty or advancing.
  - in_ready = !v[1] || stage 1 advances. in_ready has a combinational path from out_ready; this is accepted.
  - Latency is exactly PIPE cycles from accept to out_valid with no stall.
  - Throughput is 1 beat/cycle.
- Stall:
  - While out_valid && !out_ready, out_data is held stable.
  - No beat is dropped or duplicated.
  - The pipeline fills until in_ready falls.
- Config and data ordering:
  - A write commits at the clock edge where cfg_we=1.
  - A beat accepted on that same edge uses the old table.
  - Beats accepted from the next edge onward use the new table.
  - In-flight beats are never re-evaluated.
- Out-of-range write: if cfg_addr >= NUM_COM, the write is ignored and cfg_err is set. cfg_err clears only on reset.
- beat_cnt increments on each accept and holds at all-ones.
- Reset mid-operation: all in-flight beats are discarded and the tables revert to 0.

Optional Feature:
AP_COM_SHADOW_EN adds input cfg_commit (1 bit).
- Defined:
  - cfg_we writes a shadow table set.
  - A cfg_commit pulse copies every shadow entry to the active set in one edge.
  - Beats accepted on the commit edge use the old active set.
  - If cfg_we and cfg_commit coincide, the write lands in the shadow and is not part of this commit.
  - Both sets reset to 0.
- Undefined: the port is absent and writes go directly to the active tables as above.

Decomposition:
- Shared package ap_com_pkg:
  - TT_W and IN_W localparam helpers.
  - typedef tt_t (logic [TT_W-1:0]).
  - PIPE bounds check constants.
- Natural sub-module ap_com_cell:
  - Holds one truth-table register, plus its shadow when AP_COM_SHADOW_EN is defined.
  - Performs the combinational lookup.
  - Instantiated NUM_COM times by generate.
- The pipeline, counter and cfg_err logic stay in the top level.

Test Plan:
- Reset, then stream 4 beats with no config write -> out_data=0 for every beat, beat_cnt=4, first out_valid exactly PIPE cycles after the first accept.
- Write cell 0 with table 16'hFFFC and cell 2 with 16'h00CC; drive cell 0 inputs 4'b0001 and cell 2 inputs 4'b0010 -> out_data[0]=0, out_data[2]=1; all other bits 0.
- Accept a beat on the same edge as a cell-3 write of 16'hFFFF -> that beat gives out_data[3]=0; the next beat gives 1.
- Hold out_ready=0 for 6 cycles with in_valid=1 at PIPE=2 -> in_ready drops after 2 accepts and out_data is stable. Release out_ready -> ordered output with no loss or duplicates; beat_cnt matches accepts.
- Write cfg_addr=17 with NUM_COM=17 -> cfg_err=1 and all tables unchanged. Assert rst_n=0 mid-stream -> out_valid=0 and cfg_err=0 immediately.
- With AP_COM_SHADOW_EN, write cell 1 with 16'hFFFF and stream without commit -> bit 1 stays 0. Pulse cfg_commit -> beats accepted after the commit edge give bit 1=1.

Source files
------------

// File: rtl/ap_com_pkg.sv
// Shared constants and types for the approximate compressor bank.
// Ports: none (package). Optional shadow tables are enabled by the AP_COM_SHADOW_EN macro.
// Provides the default cell width, the truth-table type and legal pipeline depth bounds.
package ap_com_pkg;

  localparam int AP_IN_W  = 4;
  localparam int AP_TT_W  = 1 << AP_IN_W;
  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 3;

  typedef logic [AP_TT_W-1:0] tt_t;

  function automatic int tt_width(input int in_w);
    return 1 << in_w;
  endfunction

  function automatic bit pipe_ok(input int pipe);
    return (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX);
  endfunction

endpackage

// File: rtl/ap_com_cell.sv
// One runtime-programmable IN_W-input LUT cell; combinational lookup, zero latency.
// Ports: clk/rst_n, we+wdata load the table, [commit] (AP_COM_SHADOW_EN) copies shadow to active, sel -> y.
// No backpressure: the table is written whenever we is high; lookup is always available.
module ap_com_cell
  import ap_com_pkg::*;
#(
  parameter  int IN_W = AP_IN_W,
  localparam int TT_W = tt_width(IN_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
`ifdef AP_COM_SHADOW_EN
  input  logic            commit,
`endif
  input  logic [TT_W-1:0] wdata,
  input  logic [IN_W-1:0] sel,
  output logic            y
);

  logic [TT_W-1:0] act_q, act_d;

`ifdef AP_COM_SHADOW_EN
  logic [TT_W-1:0] shd_q, shd_d;

  // Commit copies the pre-edge shadow, so a coincident write is left for the next commit.
  always_comb begin
    shd_d = we     ? wdata : shd_q;
    act_d = commit ? shd_q : act_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_q <= '0;
      act_q <= '0;
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
    end
  end
`else
  always_comb begin
    act_d = we ? wdata : act_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end
`endif

  // Cell input 0 is the MSB of sel, so sel is used directly as the table index.
  assign y = act_q[sel];

endmodule

// File: rtl/ap_com_bank.sv
// Bank of NUM_COM programmable compressor LUTs feeding a PIPE-stage valid/ready output pipeline.
// Ports: cfg_we/cfg_addr/cfg_data program cells (cfg_commit with AP_COM_SHADOW_EN), cfg_err sticky,
// in_* beat in, out_* result out, beat_cnt saturating accept count. Latency PIPE cycles; stalls hold data.
module ap_com_bank
  import ap_com_pkg::*;
#(
  parameter  int NUM_COM = 17,
  parameter  int IN_W    = AP_IN_W,
  parameter  int PIPE    = 1,
  localparam int CFG_AW  = (NUM_COM > 1) ? $clog2(NUM_COM) : 1,
  localparam int TT_W    = tt_width(IN_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
`ifdef AP_COM_SHADOW_EN
  input  logic                    cfg_commit,
`endif
  input  logic [CFG_AW-1:0]       cfg_addr,
  input  logic [TT_W-1:0]         cfg_data,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_COM*IN_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_COM-1:0]      out_data,
  output logic [31:0]             beat_cnt
);

  if (!pipe_ok(PIPE)) begin : g_bad_pipe
    $error("ap_com_bank: PIPE out of legal range");
  end

  logic                addr_ok;
  logic [NUM_COM-1:0]  lut_y;
  logic [PIPE:0]       en;
  logic                accept;

  logic [PIPE-1:0]     v_q, v_d;
  logic [NUM_COM-1:0]  d_q [PIPE];
  logic [NUM_COM-1:0]  d_d [PIPE];
  logic [31:0]         cnt_q, cnt_d;
  logic                err_q, err_d;

  // Widened compare stays correct when NUM_COM is a power of two.
  assign addr_ok = {1'b0, cfg_addr} < (CFG_AW+1)'(NUM_COM);

  for (genvar c = 0; c < NUM_COM; c++) begin : g_cell
    ap_com_cell #(.IN_W(IN_W)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (cfg_we && addr_ok && (cfg_addr == CFG_AW'(c))),
`ifdef AP_COM_SHADOW_EN
      .commit (cfg_commit),
`endif
      .wdata  (cfg_data),
      .sel    (in_data[c*IN_W +: IN_W]),
      .y      (lut_y[c])
    );
  end

  always_comb begin
    // en[s]: stage s may load this edge (empty, or its content moves on).
    en[PIPE] = out_ready;
    for (int s = PIPE - 1; s >= 0; s--) begin
      en[s] = !v_q[s] || en[s+1];
    end
    accept = in_valid && en[0];

    v_d = v_q;
    for (int s = 0; s < PIPE; s++) begin
      d_d[s] = d_q[s];
    end
    if (en[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        d_d[0] = lut_y;
      end
    end
    for (int s = 1; s < PIPE; s++) begin
      if (en[s]) begin
        v_d[s] = v_q[s-1];
        if (v_q[s-1]) begin
          d_d[s] = d_q[s-1];
        end
      end
    end

    cnt_d = (accept && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
    err_d = err_q || (cfg_we && !addr_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int s = 0; s < PIPE; s++) begin
        d_q[s] <= '0;
      end
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      for (int s = 0; s < PIPE; s++) begin
        d_q[s] <= d_d[s];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[PIPE-1];
  assign out_data  = d_q[PIPE-1];
  assign beat_cnt  = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_ap_com_bank.sv
// Self-checking bench for ap_com_bank: directed scenarios plus a randomized phase against a table/queue model.
// Ports: none (top-level bench). Build with AP_COM_SHADOW_EN to exercise the shadow/commit path.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_ap_com_bank;
  import ap_com_pkg::*;

  localparam int NUM_COM = 17;
  localparam int IN_W    = 4;
  localparam int TB_PIPE = 2;
  localparam int CFG_AW  = $clog2(NUM_COM);
  localparam int TT_W    = 1 << IN_W;
  localparam int DW      = NUM_COM * IN_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic               cfg_commit;
  logic [CFG_AW-1:0]  cfg_addr;
  logic [TT_W-1:0]    cfg_data;
  logic               cfg_err;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_COM-1:0] out_data;
  logic [31:0]        beat_cnt;

  ap_com_bank #(.NUM_COM(NUM_COM), .IN_W(IN_W), .PIPE(TB_PIPE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
`ifdef AP_COM_SHADOW_EN
    .cfg_commit (cfg_commit),
`endif
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  tt_t                act_tt [NUM_COM];
  tt_t                shd_tt [NUM_COM];
  logic [NUM_COM-1:0] exp_q [$];
  logic [NUM_COM-1:0] out_hist [$];
  int                 n_acc;
  logic               m_err;
  logic               prev_stall;
  logic [NUM_COM-1:0] hold_dat;
  logic               last_ov;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_COM-1:0] ref_lookup(input logic [DW-1:0] dat);
    logic [NUM_COM-1:0] r;
    logic [IN_W-1:0]    k;
    for (int c = 0; c < NUM_COM; c++) begin
      k    = dat[c*IN_W +: IN_W];
      r[c] = act_tt[c][k];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_COM; c++) begin
      act_tt[c] = '0;
      shd_tt[c] = '0;
    end
    exp_q.delete();
    n_acc      = 0;
    m_err      = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock: drive at negedge, sample and score at +1ns, update model, wait for rising edge.
  task automatic cycle(input logic vld, input logic [DW-1:0] dat, input logic rdy,
                       input logic we, input int addr, input logic [TT_W-1:0] wd, input logic commit);
    logic [NUM_COM-1:0] e;
    @(negedge clk);
    in_valid   = vld;
    in_data    = dat;
    out_ready  = rdy;
    cfg_we     = we;
    cfg_addr   = CFG_AW'(addr);
    cfg_data   = wd;
    cfg_commit = commit;
    #1;
    check("beat_cnt", 64'(beat_cnt), 64'(n_acc));
    check("cfg_err", 64'(cfg_err), 64'(m_err));
    check("in_ready", 64'(in_ready), 64'((exp_q.size() < TB_PIPE) || out_ready));
    if (prev_stall) begin
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data", 64'(out_data), 64'(hold_dat));
    end
    prev_stall = out_valid && !out_ready;
    hold_dat   = out_data;
    last_ov    = out_valid;
    if (out_valid && out_ready) begin
      check("out_has_exp", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e));
        out_hist.push_back(out_data);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_lookup(in_data));
      n_acc++;
    end
`ifdef AP_COM_SHADOW_EN
    if (commit) begin
      for (int c = 0; c < NUM_COM; c++) act_tt[c] = shd_tt[c];
    end
    if (we) begin
      if (addr < NUM_COM) shd_tt[addr] = wd;
      else m_err = 1'b1;
    end
`else
    if (we) begin
      if (addr < NUM_COM) act_tt[addr] = wd;
      else m_err = 1'b1;
    end
`endif
    @(posedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, rdy, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic write_cfg(input int addr, input logic [TT_W-1:0] wd);
    cycle(1'b0, '0, 1'b1, 1'b1, addr, wd, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc0;
    logic [DW-1:0] d;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    last_ov = 1'b0; hold_dat = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_cfg_err", 64'(cfg_err), 64'(0));
    check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Empty tables: 4 beats give zeros; first result appears PIPE cycles after accept.
    cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    k = 0;
    last_ov = 1'b0;
    while (!last_ov && k < 10) begin
      k++;
      idle(1'b1);
    end
    check("latency", 64'(k), 64'(TB_PIPE));
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
    check("beat_cnt4", 64'(beat_cnt), 64'(4));
    check("zero_tables", 64'(out_hist[$]), 64'(0));

    // Programmed cells 0 and 2.
    write_cfg(0, 16'hFFFC);
    write_cfg(2, 16'h00CC);
`ifdef AP_COM_SHADOW_EN
    cycle(1'b0, '0, 1'b1, 1'b0, 0, '0, 1'b1);
`endif
    d = '0;
    d[3:0]  = 4'b0001;
    d[11:8] = 4'b0010;
    cycle(1'b1, d, 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
    check("tt_c0_c2", 64'(out_hist[$]), 64'(17'h00004));

    // Beat on the write edge sees the old table; the following beat sees the new one.
    cycle(1'b1, rand_dat(), 1'b1, 1'b1, 3, 16'hFFFF, 1'b0);
    cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
`ifndef AP_COM_SHADOW_EN
    check("same_edge_old", 64'(out_hist[$-1][3]), 64'(0));
    check("next_edge_new", 64'(out_hist[$][3]), 64'(1));
`endif

    // Stall: output blocked for 6 cycles with input always offered.
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) cycle(1'b1, rand_dat(), 1'b0, 1'b0, 0, '0, 1'b0);
    check("stall_accepts", 64'(n_acc - acc0), 64'(TB_PIPE));
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();

    // Out-of-range write: flagged, tables untouched (scoreboard confirms on following beats).
    cycle(1'b0, '0, 1'b1, 1'b1, NUM_COM, 16'hFFFF, 1'b0);
    idle(1'b1);
    check("cfg_err_set", 64'(cfg_err), 64'(1));
    for (int i = 0; i < 4; i++) cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();

    // Randomized traffic with interleaved config.
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic cm;
      we = ($urandom_range(0, 7) == 0);
      cm = ($urandom_range(0, 11) == 0);
      cycle(1'($urandom_range(0, 3) != 0), rand_dat(), 1'($urandom_range(0, 2) != 0),
            we, $urandom_range(0, 31), TT_W'($urandom), cm);
    end
    drain();

    // Reset while the pipeline is full and cfg_err is set.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_dat(), 1'b0, 1'b0, 0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_cfg_err", 64'(cfg_err), 64'(0));
    check("midrst_beat_cnt", 64'(beat_cnt), 64'(0));
    model_reset();
    in_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
    check("postrst_zero", 64'(out_hist[$]), 64'(0));

`ifdef AP_COM_SHADOW_EN
    // Shadow write is invisible until commit; commit-edge beat still uses the old set.
    write_cfg(1, 16'hFFFF);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
    check("shadow_hidden", 64'(out_hist[$][1]), 64'(0));
    cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b1);
    cycle(1'b1, rand_dat(), 1'b1, 1'b0, 0, '0, 1'b0);
    drain();
    check("commit_edge_old", 64'(out_hist[$-1][1]), 64'(0));
    check("commit_after_new", 64'(out_hist[$][1]), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
